// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with one outstanding I-cache request and a circular prefetch buffer.
// Latency: response sampled at edge E reaches the instruction queue at the earliest after edge E+1.
// Backpressure: iq_full stalls draining; a full buffer stops new requests; rdy=0 freezes the whole stage.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                INST_W    = 32,
  parameter int                BUF_DEPTH = 4,
  parameter int                PC_STEP   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  output logic                         icache_req_valid,
  output logic [ADDR_W-1:0]            icache_req_addr,
  input  logic                         icache_req_ready,
  input  logic                         icache_resp_valid,
  input  logic [INST_W-1:0]            icache_resp_inst,
  input  logic                         iq_full,
  output logic                         iq_valid,
  output logic [INST_W-1:0]            iq_inst,
  output logic [ADDR_W-1:0]            iq_pc,
  input  logic                         rob_jump_valid,
  input  logic [ADDR_W-1:0]            rob_jump_pc,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  // IDLE: nothing outstanding; REQ: request presented; WAIT: accepted, awaiting data;
  // DROP: an accepted request became stale through a redirect and its data must be swallowed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  logic [INST_W-1:0]  buf_inst [BUF_DEPTH];
  logic [ADDR_W-1:0]  buf_pc   [BUF_DEPTH];

  logic               jump;
  logic               enq;
  logic               deq;
  logic               resp_in_wait;

  // A redirect only counts while the stage is enabled; it overrides every other action.
  assign jump         = rdy && rob_jump_valid;
  assign resp_in_wait = (state == WAIT) && icache_resp_valid;

  // Enqueue only a response that belongs to the live request; responses in IDLE/REQ are ignored.
  assign enq = rdy && !jump && resp_in_wait;

  // Drain reads the pre-write head, so a response never bypasses an empty buffer.
  assign deq = rdy && !jump && (count != '0) && !iq_full;

  assign icache_req_valid = (state == REQ);
  assign icache_req_addr  = fetch_pc;
  assign buf_count        = count;

  // Occupancy after this cycle's enqueue/dequeue; simultaneous enq+deq cancels.
  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + CNT_W'(1);
    end else if (!enq && deq) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Next-state logic for the request tracker.
  always_comb begin
    state_next = state;
    if (jump) begin
      // Go to DROP whenever a request is (or is becoming) accepted but its data has not
      // arrived yet. A redirect while already dropping keeps dropping unless the stale
      // data is arriving now; otherwise that data could be mistaken for the new stream.
      if ((state == WAIT && !icache_resp_valid) ||
          (state == REQ  && icache_req_ready)   ||
          (state == DROP && !icache_resp_valid)) begin
        state_next = DROP;
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          // Reserve a slot before asking; dequeues only free space, so it stays reserved.
          if (count < DEPTH_C) begin
            state_next = REQ;
          end
        end
        REQ: begin
          if (icache_req_ready) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (icache_resp_valid) begin
            state_next = (count_next < DEPTH_C) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (icache_resp_valid) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register; rdy=0 holds the tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Fetch PC: redirect target wins, otherwise advance on every accepted instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (jump) begin
      fetch_pc <= rob_jump_pc;
    end else if (enq) begin
      fetch_pc <= fetch_pc + STEP_C;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (jump) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Buffer storage: data only, control lives in the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_inst[tail] <= icache_resp_inst;
      buf_pc[tail]   <= fetch_pc;
    end
  end

  // Registered instruction-queue interface; inst/pc hold when nothing is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_valid <= 1'b0;
      iq_inst  <= '0;
      iq_pc    <= '0;
    end else if (rdy) begin
      if (deq) begin
        iq_valid <= 1'b1;
        iq_inst  <= buf_inst[head];
        iq_pc    <= buf_pc[head];
      end else begin
        iq_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle I-cache model driven from the stimulus thread,
// hand-computed expected PCs/instructions, and cycle-exact checks around redirects and rdy stalls.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic        iq_full;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        rob_jump_valid;
  logic [31:0] rob_jump_pc;
  logic [2:0]  buf_count;

  int checks = 0;
  int errors = 0;

  // Cache model state: when auto_cache is set the bench answers each accepted request next cycle.
  logic        auto_cache;
  logic        pend;
  logic [31:0] paddr;

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_inst  (icache_resp_inst),
    .iq_full           (iq_full),
    .iq_valid          (iq_valid),
    .iq_inst           (iq_inst),
    .iq_pc             (iq_pc),
    .rob_jump_valid    (rob_jump_valid),
    .rob_jump_pc       (rob_jump_pc),
    .buf_count         (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction stored at an address in the cache model.
  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock: capture pre-edge handshake, advance, then update the cache model and monitor.
  task automatic step();
    logic        acc;
    logic        rdy_pre;
    logic        rst_pre;
    logic [31:0] addr_pre;
    rdy_pre  = rdy;
    rst_pre  = rst;
    acc      = rdy && icache_req_valid && icache_req_ready;
    addr_pre = icache_req_addr;
    @(posedge clk);
    #1;
    if (rdy_pre && auto_cache) begin
      icache_resp_valid = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        paddr = addr_pre;
      end
      if (pend) begin
        icache_resp_valid = 1'b1;
        icache_resp_inst  = mem_inst(paddr);
        pend              = 1'b0;
      end
    end
    if (rdy_pre && !rst_pre && iq_valid) begin
      got_pc.push_back(iq_pc);
      got_inst.push_back(iq_inst);
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    rdy               = 1'b1;
    auto_cache        = 1'b0;
    pend              = 1'b0;
    icache_req_ready  = 1'b1;
    icache_resp_valid = 1'b0;
    icache_resp_inst  = '0;
    iq_full           = 1'b0;
    rob_jump_valid    = 1'b0;
    rob_jump_pc       = '0;
    step();
    step();
    rst = 1'b0;
    got_pc.delete();
    got_inst.delete();
  endtask

  // Step until n instructions have been emitted or the budget runs out.
  task automatic wait_out(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (got_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(got_pc.size() >= n), 64'd1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk("rst_req_valid", 64'(icache_req_valid), 64'd0);
    chk("rst_req_addr",  64'(icache_req_addr),  64'h0);
    chk("rst_iq_valid",  64'(iq_valid),         64'd0);
    chk("rst_iq_inst",   64'(iq_inst),          64'h0);
    chk("rst_iq_pc",     64'(iq_pc),            64'h0);
    chk("rst_count",     64'(buf_count),        64'd0);

    // ---------------- sequential fetch, 1-cycle cache ----------------
    auto_cache = 1'b1;
    step();
    chk("seq_req1_valid", 64'(icache_req_valid), 64'd1);
    chk("seq_req1_addr",  64'(icache_req_addr),  64'h0);
    step();
    chk("seq_wait_valid", 64'(icache_req_valid), 64'd0);
    step();
    chk("seq_cnt1",       64'(buf_count),        64'd1);
    chk("seq_req2_addr",  64'(icache_req_addr),  64'h4);
    chk("seq_req2_valid", 64'(icache_req_valid), 64'd1);
    chk("seq_noiq_yet",   64'(iq_valid),         64'd0);
    step();
    chk("seq_iq_valid",   64'(iq_valid),         64'd1);
    chk("seq_iq_pc0",     64'(iq_pc),            64'h0);
    chk("seq_iq_inst0",   64'(iq_inst),          64'hC0DE_0000);
    chk("seq_cnt0",       64'(buf_count),        64'd0);
    wait_out("seq_timeout", 3, 40);
    if (got_pc.size() >= 3) begin
      chk("seq_pc1",   64'(got_pc[1]),   64'h4);
      chk("seq_inst1", 64'(got_inst[1]), 64'hC0DE_0004);
      chk("seq_pc2",   64'(got_pc[2]),   64'h8);
      chk("seq_inst2", 64'(got_inst[2]), 64'hC0DE_0008);
    end

    // ---------------- fill with iq_full, then drain ----------------
    do_reset();
    auto_cache = 1'b1;
    iq_full    = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("full_count",     64'(buf_count),        64'd4);
    chk("full_req_valid", 64'(icache_req_valid), 64'd0);
    chk("full_no_iq",     64'(got_pc.size()),    64'd0);
    iq_full = 1'b0;
    step();
    chk("drain0_pc",  64'(iq_pc),            64'h0);
    chk("drain0_vld", 64'(iq_valid),         64'd1);
    chk("drain0_cnt", 64'(buf_count),        64'd3);
    step();
    chk("drain1_pc",  64'(iq_pc),            64'h4);
    chk("drain1_req", 64'(icache_req_valid), 64'd1);
    chk("drain1_adr", 64'(icache_req_addr),  64'h10);
    step();
    chk("drain2_pc",  64'(iq_pc),            64'h8);
    chk("drain2_cnt", 64'(buf_count),        64'd1);
    step();
    chk("drain3_pc",  64'(iq_pc),            64'hC);
    chk("drain3_inst",64'(iq_inst),          64'hC0DE_000C);
    chk("drain3_cnt", 64'(buf_count),        64'd1);
    step();
    chk("drain4_pc",  64'(iq_pc),            64'h10);
    chk("drain4_vld", 64'(iq_valid),         64'd1);

    // ---------------- redirect in WAIT, stale response later ----------------
    do_reset();
    step();
    step();
    rob_jump_valid = 1'b1;
    rob_jump_pc    = 32'h100;
    step();
    rob_jump_valid = 1'b0;
    chk("rdw_drop_req", 64'(icache_req_valid), 64'd0);
    step();
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'hDEAD_BEEF;
    step();
    icache_resp_valid = 1'b0;
    chk("rdw_count",    64'(buf_count),        64'd0);
    chk("rdw_idle_req", 64'(icache_req_valid), 64'd0);
    step();
    chk("rdw_req_valid",64'(icache_req_valid), 64'd1);
    chk("rdw_req_addr", 64'(icache_req_addr),  64'h100);
    auto_cache = 1'b1;
    wait_out("rdw_timeout", 1, 20);
    if (got_pc.size() >= 1) begin
      chk("rdw_first_pc",   64'(got_pc[0]),   64'h100);
      chk("rdw_first_inst", 64'(got_inst[0]), 64'hC0DE_0100);
    end

    // ---------------- redirect with resp_valid in WAIT ----------------
    do_reset();
    step();
    step();
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'h1111_1111;
    rob_jump_valid    = 1'b1;
    rob_jump_pc       = 32'h200;
    step();
    icache_resp_valid = 1'b0;
    rob_jump_valid    = 1'b0;
    chk("rjr_count",    64'(buf_count),        64'd0);
    chk("rjr_idle_req", 64'(icache_req_valid), 64'd0);
    step();
    chk("rjr_req_addr", 64'(icache_req_addr),  64'h200);
    chk("rjr_req_vld",  64'(icache_req_valid), 64'd1);
    chk("rjr_no_iq",    64'(iq_valid),         64'd0);
    auto_cache = 1'b1;
    wait_out("rjr_timeout", 1, 20);
    if (got_pc.size() >= 1) begin
      chk("rjr_first_pc", 64'(got_pc[0]), 64'h200);
    end

    // ---------------- redirect with req_ready in REQ ----------------
    do_reset();
    step();
    rob_jump_valid = 1'b1;
    rob_jump_pc    = 32'h200;
    step();
    rob_jump_valid = 1'b0;
    chk("rqr_drop_req", 64'(icache_req_valid), 64'd0);
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'h2222_2222;
    step();
    icache_resp_valid = 1'b0;
    chk("rqr_count",    64'(buf_count),        64'd0);
    chk("rqr_idle_req", 64'(icache_req_valid), 64'd0);
    step();
    chk("rqr_req_addr", 64'(icache_req_addr),  64'h200);
    auto_cache = 1'b1;
    wait_out("rqr_timeout", 1, 20);
    if (got_pc.size() >= 1) begin
      chk("rqr_first_pc",   64'(got_pc[0]),   64'h200);
      chk("rqr_first_inst", 64'(got_inst[0]), 64'hC0DE_0200);
    end

    // ---------------- stream of 12 with toggling iq_full ----------------
    do_reset();
    auto_cache = 1'b1;
    for (int k = 0; k < 300 && got_pc.size() < 12; k++) begin
      iq_full = ~iq_full;
      step();
    end
    chk("strm_count", 64'(got_pc.size() >= 12), 64'd1);
    for (int i = 0; i < 12 && i < got_pc.size(); i++) begin
      chk($sformatf("strm_pc%0d", i),   64'(got_pc[i]),   64'(32'(i * 4)));
      chk($sformatf("strm_inst%0d", i), 64'(got_inst[i]), 64'(32'hC0DE_0000 ^ 32'(i * 4)));
    end

    // ---------------- rdy=0 freeze mid-WAIT ----------------
    do_reset();
    auto_cache = 1'b1;
    step();
    step();
    step();
    auto_cache = 1'b0;
    step();
    chk("frz_pre_vld",  64'(iq_valid),         64'd1);
    chk("frz_pre_pc",   64'(iq_pc),            64'h0);
    chk("frz_pre_req",  64'(icache_req_valid), 64'd0);
    rdy               = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_inst  = 32'h3333_3333;
    rob_jump_valid    = 1'b1;
    rob_jump_pc       = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz%0d_iq_vld", i), 64'(iq_valid),         64'd1);
      chk($sformatf("frz%0d_iq_pc", i),  64'(iq_pc),            64'h0);
      chk($sformatf("frz%0d_iq_inst", i),64'(iq_inst),          64'hC0DE_0000);
      chk($sformatf("frz%0d_req", i),    64'(icache_req_valid), 64'd0);
      chk($sformatf("frz%0d_addr", i),   64'(icache_req_addr),  64'h4);
      chk($sformatf("frz%0d_cnt", i),    64'(buf_count),        64'd0);
    end
    rdy              = 1'b1;
    rob_jump_valid   = 1'b0;
    icache_resp_inst = 32'hC0DE_0004;
    step();
    icache_resp_valid = 1'b0;
    chk("res_cnt",      64'(buf_count),        64'd1);
    chk("res_req_vld",  64'(icache_req_valid), 64'd1);
    chk("res_req_addr", 64'(icache_req_addr),  64'h8);
    chk("res_iq_vld",   64'(iq_valid),         64'd0);
    step();
    chk("res_iq_vld2",  64'(iq_valid),         64'd1);
    chk("res_iq_pc",    64'(iq_pc),            64'h4);
    chk("res_iq_inst",  64'(iq_inst),          64'hC0DE_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
